reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port integer register file for the RV32 datapath: `NRD` read ports, `NWR` write ports, and a same-cycle write-to-read bypass. It has a per-register busy scoreboard for pipeline hazard detection and a sequential post-reset clear engine, so the array can map to non-resettable storage. It sits between decode/issue, which reads and marks destinations busy, and writeback, which writes and clears busy.

## Interface
- `XLEN`, 32: data width.
- `NREGS`, 32: number of registers; power of two, ≥ 2; entry 0 is hard-wired zero.
- `NRD`, 2: number of read ports, 1..4.
- `NWR`, 1: number of write ports, 1..2.
- `AW`, `$clog2(NREGS)`: address width (derived, not overridden).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `init_done`  out  1  high once the post-reset clear completes.
- `we`  in  `[NWR]`  per-port write enable.
- `wr_addr`  in  `[NWR][AW]`  write address.
- `wr_data`  in  `[NWR][XLEN]`  write data.
- `rd_addr`  in  `[NRD][AW]`  read address.
- `rd_data`  out  `[NRD][XLEN]`  read data, combinational.
- `rd_busy`  out  `[NRD]`  busy bit of the register at `rd_addr`, combinational.
- `iss_valid`  in  1  issue marks destination busy.
- `iss_addr`  in  `AW`  destination being issued.

## Operation
- The FSM has two states: INIT and RUN.
- Reset assertion (async):
  - FSM goes to INIT, clear counter goes to 0, all busy bits go to 0, `init_done`=0.
  - The storage array is not reset.
- INIT:
  - Each cycle writes 0 to entry `cnt`, then increments `cnt`.
  - When `cnt`==`NREGS-1` is cleared, the FSM goes to RUN.
  - `we` and `iss_valid` are ignored.
  - `rd_data`=0 and `rd_busy`=0 on all ports.
- RUN, write:
  - On a clock edge, for each port with `we`=1 and `wr_addr`≠0, entry `wr_addr` ← `wr_data`.
  - When `NWR`=2 and both ports target the same address, port 1 wins.
- RUN, read:
  - `rd_addr`=0 returns 0.
  - Otherwise, if any port writes that address this cycle, return its `wr_data` (bypass; port 1 has priority).
  - Otherwise return the array value.
- Scoreboard:
  - `iss_valid` with `iss_addr`≠0 sets busy[`iss_addr`] on the next edge.
  - Any active write clears busy[`wr_addr`] on the next edge.
  - Simultaneous set and clear of the same entry: set wins, because a new producer supersedes the old one.
  - busy[0] is constant 0.
- `rd_busy`:
  - Equals busy[`rd_addr`], masked to 0 when a write to that address is present this cycle, consistent with the bypass.
  - A same-cycle `iss_valid` to that address is not visible until the next cycle.
- Width rules:
  - Addresses are used unsigned, with no out-of-range handling because `NREGS`=2^`AW`.
  - The clear counter is `AW` bits wide.

## Timing
- After `rst_n` deasserts, edge k (k=1..`NREGS`) clears entry k-1.
- `init_done` rises after edge `NREGS` and stays 1 until the next reset.
- Write latency to the array is 1 edge; read-after-write in the same cycle has 0 latency via the bypass.
- Busy set and clear take effect 1 edge after the request.
- Reset mid-INIT or mid-RUN restarts INIT from entry 0 immediately (async).
- Outputs during reset: `init_done`=0, `rd_data`=0, `rd_busy`=0.

## Structure
- Package `reg_file_pkg`:
  - `XLEN` and `NREGS` defaults.
  - `rf_state_t` enum {INIT, RUN}.
  - `reg_addr_t` typedef (logic [AW-1:0]).
- Sub-module `reg_file_scoreboard`:
  - Holds the `NREGS`-bit busy vector with set/clear priority and the `rd_busy` masking.
  - Instanced once.
- The top contains the FSM, clear counter, array, write arbitration and bypass muxes.

## Test plan
- Reset, then release `rst_n` with `NREGS`=32 → `init_done`=0 for 32 edges, 1 after edge 32; every `rd_addr` reads 0x0 once `init_done`=1.
- RUN: write 0xDEADBEEF to x5 while `rd_addr[0]`=5 the same cycle → `rd_data[0]`=0xDEADBEEF combinationally, and still 0xDEADBEEF next cycle with `we`=0.
- Write 0x12345678 to x0 → subsequent read of x0 returns 0, and busy[0] stays 0 after `iss_valid` to x0.
- `NWR`=2, both ports write x7 (0xAAAA0000, 0x5555FFFF) → x7 reads 0x5555FFFF.
- `iss_valid` to x3 → `rd_busy` for x3 is 1 next cycle; write x3 with `iss_valid` to x3 in the same cycle → busy stays 1; write x3 alone → busy 0 next cycle.
- Assert `rst_n`=0 at INIT entry 10 after RUN data was written to x20 → INIT restarts at 0 and x20 reads 0 after `init_done`.

Source files
------------

// File: rtl/reg_file_pkg.sv
//------------------------------------------------------------------------------
// Module      : reg_file_pkg
// Description : Shared types and default sizes for the multi-port RV32
//               integer register file.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package reg_file_pkg;

    // Default sizing for an RV32I integer register file
    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;
    localparam int RF_AW_DEF    = $clog2(RF_NREGS_DEF);

    // Two-state controller: sequential clear after reset, then normal operation
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_t;

    // Register index for the default-sized file
    typedef logic [RF_AW_DEF-1:0] reg_addr_t;

endpackage : reg_file_pkg

`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
//------------------------------------------------------------------------------
// Module      : reg_file_scoreboard
// Description : Per-register busy vector for hazard detection. Issue sets a
//               bit, writeback clears it; a same-edge set beats a clear since
//               the newer producer supersedes the older one. Read-side busy is
//               masked when a write to the same register is in flight so it
//               stays consistent with the data bypass.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter  int NREGS = RF_NREGS_DEF,
    parameter  int NRD   = 2,
    parameter  int NWR   = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_run,
    input  logic                     i_set_valid,
    input  logic [AW-1:0]            i_set_addr,
    input  logic [NWR-1:0]           i_clr_valid,
    input  logic [NWR-1:0][AW-1:0]   i_clr_addr,
    input  logic [NRD-1:0][AW-1:0]   i_rd_addr,
    input  logic [NRD-1:0]           i_rd_hit,
    output logic [NRD-1:0]           o_rd_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_clr_mask;
    logic [NREGS-1:0] w_busy_nxt;

    // Decode set/clear requests; set is applied after clear so it wins
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_valid) begin
            w_set_mask[i_set_addr] = 1'b1;
        end
        for (int p = 0; p < NWR; p++) begin
            if (i_clr_valid[p]) begin
                w_clr_mask[i_clr_addr[p]] = 1'b1;
            end
        end
        w_busy_nxt    = (r_busy & ~w_clr_mask) | w_set_mask;
        w_busy_nxt[0] = 1'b0;
    end

    // Busy vector: cleared on reset, updated every edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Read-side busy, hidden while clearing and when a write bypasses the value
    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            o_rd_busy[r] = i_run & r_busy[i_rd_addr[r]] & ~i_rd_hit[r];
        end
    end

endmodule : reg_file_scoreboard

`default_nettype wire

// File: rtl/reg_file_mp.sv
//------------------------------------------------------------------------------
// Module      : reg_file_mp
// Description : Parametrised multi-port integer register file with same-cycle
//               write-to-read bypass, busy scoreboard and a sequential
//               post-reset clear so the array itself needs no reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter  int XLEN  = RF_XLEN_DEF,
    parameter  int NREGS = RF_NREGS_DEF,
    parameter  int NRD   = 2,
    parameter  int NWR   = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         init_done,
    input  logic [NWR-1:0]               we,
    input  logic [NWR-1:0][AW-1:0]       wr_addr,
    input  logic [NWR-1:0][XLEN-1:0]     wr_data,
    input  logic [NRD-1:0][AW-1:0]       rd_addr,
    output logic [NRD-1:0][XLEN-1:0]     rd_data,
    output logic [NRD-1:0]               rd_busy,
    input  logic                         iss_valid,
    input  logic [AW-1:0]                iss_addr
);

    localparam logic [AW-1:0] c_LAST = AW'(NREGS - 1);

    rf_state_t          r_state;
    logic [AW-1:0]      r_cnt;
    logic [XLEN-1:0]    r_mem [NREGS];

    logic               w_run;
    logic [NWR-1:0]     w_wr_act;
    logic [NRD-1:0]     w_rd_hit;
    logic               w_set_valid;

    assign w_run     = (r_state == RUN);
    assign init_done = w_run;

    // Qualified writes: only in RUN, and never to the hard-wired zero entry
    always_comb begin
        for (int p = 0; p < NWR; p++) begin
            w_wr_act[p] = w_run & we[p] & (wr_addr[p] != '0);
        end
    end

    assign w_set_valid = w_run & iss_valid & (iss_addr != '0);

    // Controller: walk the clear counter through every entry, then run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else if (r_state == INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
                r_state <= RUN;
            end
        end
    end

    // Storage array (no reset): clear one entry per edge in INIT, else writes;
    // later ports are assigned last so port 1 wins an address collision
    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (w_wr_act[p]) begin
                    r_mem[wr_addr[p]] <= wr_data[p];
                end
            end
        end
    end

    // Read muxes: zero entry and INIT read 0; in-flight writes bypass the array
    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rd_data[r]  = '0;
            w_rd_hit[r] = 1'b0;
            if (w_run && (rd_addr[r] != '0)) begin
                rd_data[r] = r_mem[rd_addr[r]];
                for (int p = 0; p < NWR; p++) begin
                    if (w_wr_act[p] && (wr_addr[p] == rd_addr[r])) begin
                        rd_data[r]  = wr_data[p];
                        w_rd_hit[r] = 1'b1;
                    end
                end
            end
        end
    end

    reg_file_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_run       (w_run),
        .i_set_valid (w_set_valid),
        .i_set_addr  (iss_addr),
        .i_clr_valid (w_wr_act),
        .i_clr_addr  (wr_addr),
        .i_rd_addr   (rd_addr),
        .i_rd_hit    (w_rd_hit),
        .o_rd_busy   (rd_busy)
    );

endmodule : reg_file_mp

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
//------------------------------------------------------------------------------
// Module      : tb_reg_file_mp
// Description : Directed self-checking bench for reg_file_mp (NRD=2, NWR=2).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                         clk;
    logic                         rst_n;
    logic                         init_done;
    logic [NWR-1:0]               we;
    logic [NWR-1:0][AW-1:0]       wr_addr;
    logic [NWR-1:0][XLEN-1:0]     wr_data;
    logic [NRD-1:0][AW-1:0]       rd_addr;
    logic [NRD-1:0][XLEN-1:0]     rd_data;
    logic [NRD-1:0]               rd_busy;
    logic                         iss_valid;
    logic [AW-1:0]                iss_addr;

    int total = 0;
    int bad   = 0;

    reg_file_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; inputs change 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we        = '0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
    endtask

    initial begin
        rst_n   = 1'b0;
        rd_addr = '0;
        idle();
        tick();
        tick();
        #1;
        chk("reset_init_done", {31'd0, init_done}, 32'd0);
        chk("reset_rd_data0",  rd_data[0], 32'd0);
        chk("reset_rd_busy",   {30'd0, rd_busy}, 32'd0);

        // Release reset between edges; edge k clears entry k-1
        rst_n = 1'b1;
        for (int k = 1; k <= NREGS; k++) begin
            tick();
            chk($sformatf("init_done_edge%0d", k), {31'd0, init_done}, (k == NREGS) ? 32'd1 : 32'd0);
        end

        // Every entry reads zero after the clear
        for (int a = 0; a < NREGS; a++) begin
            rd_addr[0] = AW'(a);
            rd_addr[1] = AW'(NREGS - 1 - a);
            #1;
            chk($sformatf("clear_rd0_x%0d", a), rd_data[0], 32'd0);
            chk($sformatf("clear_rd1_x%0d", NREGS - 1 - a), rd_data[1], 32'd0);
        end

        // Same-cycle bypass, then array value next cycle
        we = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF; rd_addr[0] = 5'd5;
        #1;
        chk("bypass_x5", rd_data[0], 32'hDEADBEEF);
        tick();
        idle();
        #1;
        chk("array_x5", rd_data[0], 32'hDEADBEEF);

        // Writes to x0 are dropped; issue to x0 never sets busy
        we = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'h12345678; rd_addr[0] = 5'd0;
        #1;
        chk("x0_bypass", rd_data[0], 32'd0);
        tick();
        idle();
        iss_valid = 1'b1; iss_addr = 5'd0;
        #1;
        chk("x0_after_write", rd_data[0], 32'd0);
        tick();
        idle();
        #1;
        chk("x0_busy", {31'd0, rd_busy[0]}, 32'd0);

        // Dual write collision: port 1 wins in bypass and array
        we = 2'b11; wr_addr[0] = 5'd7; wr_addr[1] = 5'd7;
        wr_data[0] = 32'hAAAA0000; wr_data[1] = 32'h5555FFFF; rd_addr[1] = 5'd7;
        #1;
        chk("dual_bypass_x7", rd_data[1], 32'h5555FFFF);
        tick();
        idle();
        #1;
        chk("dual_array_x7", rd_data[1], 32'h5555FFFF);

        // Busy set is visible one edge later
        rd_addr[0] = 5'd3; iss_valid = 1'b1; iss_addr = 5'd3;
        #1;
        chk("busy_x3_same_cycle", {31'd0, rd_busy[0]}, 32'd0);
        tick();
        idle();
        #1;
        chk("busy_x3_set", {31'd0, rd_busy[0]}, 32'd1);

        // Write plus issue to x3: read side masked now, set wins afterwards
        we = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h00000033; iss_valid = 1'b1; iss_addr = 5'd3;
        #1;
        chk("busy_x3_masked", {31'd0, rd_busy[0]}, 32'd0);
        chk("data_x3_bypass", rd_data[0], 32'h00000033);
        tick();
        idle();
        #1;
        chk("busy_x3_set_wins", {31'd0, rd_busy[0]}, 32'd1);

        // Plain write clears busy
        we = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h00000044;
        tick();
        idle();
        #1;
        chk("busy_x3_cleared", {31'd0, rd_busy[0]}, 32'd0);
        chk("data_x3", rd_data[0], 32'h00000044);

        // Write port 1 also clears busy; read port 1 sees it too
        iss_valid = 1'b1; iss_addr = 5'd9; rd_addr[1] = 5'd9;
        tick();
        idle();
        #1;
        chk("busy_x9_set_p1", {31'd0, rd_busy[1]}, 32'd1);
        we = 2'b10; wr_addr[1] = 5'd9; wr_data[1] = 32'h99990000;
        tick();
        idle();
        #1;
        chk("busy_x9_clr_p1", {31'd0, rd_busy[1]}, 32'd0);
        chk("data_x9", rd_data[1], 32'h99990000);

        // Leave x3 busy, write x20, then reset asynchronously
        iss_valid = 1'b1; iss_addr = 5'd3;
        we = 2'b01; wr_addr[0] = 5'd20; wr_data[0] = 32'hCAFEF00D;
        tick();
        idle();
        rd_addr[0] = 5'd20; rd_addr[1] = 5'd3;
        #1;
        chk("run_x20", rd_data[0], 32'hCAFEF00D);
        chk("run_busy_x3", {31'd0, rd_busy[1]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_init_done", {31'd0, init_done}, 32'd0);
        chk("async_rst_rd_data", rd_data[0], 32'd0);
        chk("async_rst_rd_busy", {31'd0, rd_busy[1]}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Clear entries 0..9, then reset again at entry 10
        for (int k = 1; k <= 10; k++) begin
            tick();
        end
        #1;
        chk("mid_init_done", {31'd0, init_done}, 32'd0);
        chk("mid_init_rd_x20", rd_data[0], 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Full restart; writes and issues during INIT are ignored
        for (int k = 1; k <= NREGS; k++) begin
            tick();
            idle();
            if (k >= 10 && k <= 25) begin
                we = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'h00000BAD;
                iss_valid = 1'b1; iss_addr = 5'd6;
            end
            if (k == NREGS - 1) begin
                #1;
                chk("restart_init_done_31", {31'd0, init_done}, 32'd0);
            end
        end
        idle();
        #1;
        chk("restart_init_done_32", {31'd0, init_done}, 32'd1);
        rd_addr[0] = 5'd20; rd_addr[1] = 5'd5;
        #1;
        chk("restart_x20", rd_data[0], 32'd0);
        chk("restart_x5", rd_data[1], 32'd0);
        rd_addr[0] = 5'd6; rd_addr[1] = 5'd3;
        #1;
        chk("restart_busy_x6", {31'd0, rd_busy[0]}, 32'd0);
        chk("restart_busy_x3", {31'd0, rd_busy[1]}, 32'd0);
        rd_addr[0] = 5'd7; rd_addr[1] = 5'd9;
        #1;
        chk("restart_x7", rd_data[0], 32'd0);
        chk("restart_x9", rd_data[1], 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_file_mp

`default_nettype wire
